// File: rtl/bp_multi_if.sv
// Host-side configuration, display and CPU bus signals of the multi-channel breakpoint unit.
// The slave modport is the bp_multi side; master is the CPU/debug-host side.
interface bp_multi_if #(
  parameter int NUM_BP = 4,
  parameter int ADDR_W = 16,
  parameter int PART_W = 8
) ();
  localparam int NPART  = ADDR_W / PART_W;
  localparam int PSEL_W = (NPART  > 1) ? $clog2(NPART)  : 1;
  localparam int CSEL_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  logic [PART_W-1:0] bp_addr_part_in;
  logic [PSEL_W-1:0] bp_part_sel;
  logic [CSEL_W-1:0] bp_chan_sel;
  logic              bp_load;
  logic [1:0]        bp_mode_in;
  logic              bp_mode_load;
  logic [PART_W-1:0] bp_addr_disp;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_fetch;
  logic              mem_re;
  logic              mem_we;
  logic              bp_step;
  logic              bp_continue;
  logic              bp_halt;
  logic [CSEL_W-1:0] bp_hit_chan;
  logic              bp_hit_valid;

  modport slave (
    input  bp_addr_part_in, bp_part_sel, bp_chan_sel, bp_load,
    input  bp_mode_in, bp_mode_load,
    input  cpu_addr, cpu_fetch, mem_re, mem_we,
    input  bp_step, bp_continue,
    output bp_addr_disp, bp_halt, bp_hit_chan, bp_hit_valid
  );

  modport master (
    output bp_addr_part_in, bp_part_sel, bp_chan_sel, bp_load,
    output bp_mode_in, bp_mode_load,
    output cpu_addr, cpu_fetch, mem_re, mem_we,
    output bp_step, bp_continue,
    input  bp_addr_disp, bp_halt, bp_hit_chan, bp_hit_valid
  );
endinterface

// File: rtl/bp_multi.sv
// Multi-channel address breakpoint unit: per-channel address/mode registers loaded in slices,
// a priority match, and a RUN/BREAK/STEP/SKIP controller that stalls the CPU on a hit.
module bp_multi #(
  parameter int              NUM_BP     = 4,
  parameter int              ADDR_W     = 16,
  parameter int              PART_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(16'hffff)
) (
  input logic       clock,
  input logic       reset,
  bp_multi_if.slave bus
);
  localparam int NPART  = ADDR_W / PART_W;
  localparam int CSEL_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
  localparam int PSEL_W = (NPART  > 1) ? $clog2(NPART)  : 1;

  typedef enum logic [1:0] {RUN, BREAK, STEP, SKIP} state_e;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_EXEC  = 2'b01;
  localparam logic [1:0] MODE_READ  = 2'b10;
  localparam logic [1:0] MODE_WRITE = 2'b11;

  logic [ADDR_W-1:0] chan_addr [NUM_BP];
  logic [1:0]        chan_mode [NUM_BP];

  state_e            state_q, state_d;
  logic [CSEL_W-1:0] hit_chan_q, hit_chan_d;
  logic              hit_valid_q, hit_valid_d;

  logic [NUM_BP-1:0] match;
  logic              any_match;
  logic [CSEL_W-1:0] win_chan;
  logic              fetch_cyc;

  assign fetch_cyc = bus.cpu_fetch & bus.mem_re;

  // NOTE: the channel register file is reset explicitly because its reset contents
  // (RESET_ADDR, channel 0 armed for exec) are architecturally visible, unlike a plain RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_BP; c++) begin
        chan_addr[c] <= RESET_ADDR;
        chan_mode[c] <= (c == 0) ? MODE_EXEC : MODE_OFF;
      end
    end else begin
      // Out-of-range selects simply match no channel/slice and are dropped.
      for (int c = 0; c < NUM_BP; c++) begin
        if (bus.bp_chan_sel == CSEL_W'(c)) begin
          if (bus.bp_mode_load) chan_mode[c] <= bus.bp_mode_in;
          for (int p = 0; p < NPART; p++) begin
            if (bus.bp_load && bus.bp_part_sel == PSEL_W'(p))
              chan_addr[c][p*PART_W +: PART_W] <= bus.bp_addr_part_in;
          end
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default before any conditional assignment,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.bp_addr_disp = '0;
    for (int c = 0; c < NUM_BP; c++) begin
      for (int p = 0; p < NPART; p++) begin
        if (bus.bp_chan_sel == CSEL_W'(c) && bus.bp_part_sel == PSEL_W'(p))
          bus.bp_addr_disp = chan_addr[c][p*PART_W +: PART_W];
      end
    end
  end

  always_comb begin
    match = '0;
    for (int c = 0; c < NUM_BP; c++) begin
      if (bus.cpu_addr == chan_addr[c]) begin
        unique case (chan_mode[c])
          MODE_EXEC:  match[c] = bus.cpu_fetch & bus.mem_re;
          MODE_READ:  match[c] = bus.mem_re & ~bus.cpu_fetch;
          MODE_WRITE: match[c] = bus.mem_we;
          default:    match[c] = 1'b0;
        endcase
      end
    end
  end

  // Scan downward so the lowest-numbered matching channel is the last one written.
  always_comb begin
    win_chan = '0;
    for (int c = NUM_BP - 1; c >= 0; c--) begin
      if (match[c]) win_chan = CSEL_W'(c);
    end
  end

  assign any_match = |match;

  always_comb begin
    state_d     = state_q;
    hit_chan_d  = hit_chan_q;
    hit_valid_d = hit_valid_q;
    unique case (state_q)
      RUN: begin
        if (any_match) begin
          state_d     = BREAK;
          hit_chan_d  = win_chan;
          hit_valid_d = 1'b1;
        end
      end
      BREAK: begin
        if (bus.bp_continue)  state_d = SKIP;
        else if (bus.bp_step) state_d = STEP;
      end
      STEP: begin
        // A step break keeps the last channel but marks it as not caused by a match.
        if (fetch_cyc) begin
          state_d     = BREAK;
          hit_valid_d = 1'b0;
        end
      end
      SKIP: begin
        // The one fetch at the breakpoint address executes before matching resumes.
        if (fetch_cyc) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      hit_chan_q  <= '0;
      hit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_chan_q  <= hit_chan_d;
      hit_valid_q <= hit_valid_d;
    end
  end

  // Decoded straight from the asynchronously reset state, so reset drops the stall at once.
  assign bus.bp_halt      = (state_q == BREAK);
  assign bus.bp_hit_chan  = hit_chan_q;
  assign bus.bp_hit_valid = hit_valid_q;

endmodule
